// File: rtl/mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_pkg : shared size/state encodings and memory geometry for mem_lsu
// Revision: 1.0
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int MEM_DEPTH_LOG2 = 8;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_lsu_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_lsu_if : request/response channel plus data-memory port of mem_lsu
// Revision: 1.0
// ---------------------------------------------------------------------------
interface mem_lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_we;
  logic [63:0] mem_rdata;

  // LSU side
  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wdata, mem_we
  );

  // Datapath and memory side
  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_wdata, mem_we
  );

endinterface
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_lane : byte-lane extract/extend for loads and byte-lane merge for stores
// Revision: 1.0
// ---------------------------------------------------------------------------
module lsu_lane
  import mem_pkg::*;
(
  input  logic [2:0]  i_offset,
  input  size_e       i_size,
  input  logic        i_unsigned,
  input  logic [63:0] i_rdata,
  input  logic [63:0] i_base,
  input  logic [63:0] i_wdata,
  output logic [63:0] o_load,
  output logic [63:0] o_merged
);

  logic [63:0] w_shifted;
  logic [63:0] w_wshift;
  logic [63:0] w_bitmask;
  logic [7:0]  w_size_mask;
  logic [7:0]  w_bytemask;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};
  assign w_wshift  = i_wdata << {i_offset, 3'b000};

  always_comb begin
    o_load = w_shifted;
    case (i_size)
      SZ_B:    o_load = {{56{~i_unsigned & w_shifted[7]}},  w_shifted[7:0]};
      SZ_H:    o_load = {{48{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      SZ_W:    o_load = {{32{~i_unsigned & w_shifted[31]}}, w_shifted[31:0]};
      default: o_load = w_shifted;
    endcase
  end

  // Offsets are already aligned to the size, so the shifted mask never wraps.
  always_comb begin
    w_size_mask = 8'hFF;
    case (i_size)
      SZ_B:    w_size_mask = 8'h01;
      SZ_H:    w_size_mask = 8'h03;
      SZ_W:    w_size_mask = 8'h0F;
      default: w_size_mask = 8'hFF;
    endcase
    w_bytemask = w_size_mask << i_offset;
    w_bitmask  = '0;
    for (int b = 0; b < 8; b++) begin
      w_bitmask[8*b +: 8] = {8{w_bytemask[b]}};
    end
  end

  assign o_merged = (i_base & ~w_bitmask) | (w_wshift & w_bitmask);

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_lsu : byte-addressed load/store initiator for a doubleword-indexed RAM
// Revision: 1.0
// ---------------------------------------------------------------------------
module mem_lsu
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = MEM_DEPTH_LOG2,
  parameter int XLEN       = 64
) (
  input  logic      clock,
  input  logic      reset,
  mem_lsu_if.slave  bus,
  output logic      busy
);

  state_e                r_state;
  state_e                w_next;
  logic [DEPTH_LOG2-1:0] r_index;
  logic [2:0]            r_offset;
  size_e                 r_size;
  logic                  r_store;
  logic                  r_unsigned;
  logic                  r_err;
  logic [XLEN-1:0]       r_wdata;
  logic [XLEN-1:0]       r_merge;
  logic [XLEN-1:0]       r_rdata;

  size_e                 w_req_size;
  logic                  w_misalign;
  logic                  w_range_err;
  logic                  w_err;
  logic                  w_accept;
  logic [XLEN-1:0]       w_load;
  logic [XLEN-1:0]       w_merged;
  logic [XLEN-1:0]       w_index_ext;

  logic                  w_req_ready;
  logic                  w_resp_valid;
  logic [XLEN-1:0]       w_resp_rdata;
  logic                  w_resp_err;
  logic [XLEN-1:0]       w_mem_addr;
  logic [XLEN-1:0]       w_mem_wdata;
  logic                  w_mem_we;

  assign w_req_size = size_e'(bus.req_size);

  always_comb begin
    w_misalign = 1'b0;
    case (w_req_size)
      SZ_B:    w_misalign = 1'b0;
      SZ_H:    w_misalign = bus.req_addr[0];
      SZ_W:    w_misalign = |bus.req_addr[1:0];
      default: w_misalign = |bus.req_addr[2:0];
    endcase
  end

  assign w_range_err = |bus.req_addr[XLEN-1:DEPTH_LOG2+3];
  assign w_err       = w_misalign | w_range_err;
  assign w_accept    = bus.req_valid && (r_state == IDLE);
  assign w_index_ext = {{(XLEN-DEPTH_LOG2){1'b0}}, r_index};

  // Load extract reads the live port; merge works on the captured old entry.
  lsu_lane u_lane (
    .i_offset   (r_offset),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_rdata    (bus.mem_rdata),
    .i_base     (r_merge),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_index    <= '0;
      r_offset   <= '0;
      r_size     <= SZ_B;
      r_store    <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_wdata    <= '0;
      r_merge    <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_index    <= bus.req_addr[DEPTH_LOG2+2:3];
        r_offset   <= bus.req_addr[2:0];
        r_size     <= w_req_size;
        r_store    <= bus.req_store;
        r_unsigned <= bus.req_unsigned;
        r_wdata    <= bus.req_wdata;
        r_err      <= w_err;
        r_rdata    <= '0;
      end
      if (r_state == ACCESS) begin
        if (!r_store) r_rdata <= w_load;
        else          r_merge <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    w_resp_rdata = '0;
    w_resp_err   = 1'b0;
    w_mem_addr   = '0;
    w_mem_wdata  = '0;
    w_mem_we     = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) w_next = w_err ? RESP : ACCESS;
      end
      ACCESS: begin
        w_mem_addr = w_index_ext;
        if (r_store && (r_size == SZ_D)) begin
          w_mem_we    = 1'b1;
          w_mem_wdata = r_wdata;
          w_next      = RESP;
        end else if (r_store) begin
          w_next = WRITE;
        end else begin
          w_next = RESP;
        end
      end
      WRITE: begin
        w_mem_addr  = w_index_ext;
        w_mem_we    = 1'b1;
        w_mem_wdata = w_merged;
        w_next      = RESP;
      end
      RESP: begin
        w_resp_valid = 1'b1;
        w_resp_rdata = r_rdata;
        w_resp_err   = r_err;
        if (bus.resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_rdata = w_resp_rdata;
  assign bus.resp_err   = w_resp_err;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_wdata  = w_mem_wdata;
  assign bus.mem_we     = w_mem_we;
  assign busy           = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_lsu : directed scoreboard bench for mem_lsu with a behavioural RAM
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mem_lsu;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy;

  mem_lsu_if bus ();

  mem_lsu #(.DEPTH_LOG2(8), .XLEN(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  logic [63:0] mem [256];
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
  always @(posedge clock) if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks   = 0;
  int   n_err      = 0;
  int   we_cycles  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts write cycles and scores every response handshake.
  always @(negedge clock) begin
    exp_t e;
    if (bus.mem_we) begin
      we_cycles++;
      chk("mem_addr_range", {63'b0, (bus.mem_addr < 64'd256)}, 64'd1);
    end
    if (!reset && bus.resp_valid && bus.resp_ready) begin
      chk("sb_outstanding", 64'(sb.size()), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_err", {63'b0, bus.resp_err}, {63'b0, e.err});
      end
    end
  end

  task automatic check_reset_outputs(input string p);
    chk({p, "_req_ready"},  {63'b0, bus.req_ready},  64'd1);
    chk({p, "_resp_valid"}, {63'b0, bus.resp_valid}, 64'd0);
    chk({p, "_resp_err"},   {63'b0, bus.resp_err},   64'd0);
    chk({p, "_resp_rdata"}, bus.resp_rdata,          64'd0);
    chk({p, "_mem_we"},     {63'b0, bus.mem_we},     64'd0);
    chk({p, "_mem_addr"},   bus.mem_addr,            64'd0);
    chk({p, "_mem_wdata"},  bus.mem_wdata,           64'd0);
    chk({p, "_busy"},       {63'b0, busy},           64'd0);
  endtask

  task automatic issue(input bit st, input int sz, input bit uns, input logic [63:0] a,
                       input logic [63:0] wd, input bit push, input logic [63:0] er, input bit ee);
    int   n = 0;
    exp_t e;
    @(negedge clock);
    bus.req_valid    = 1'b1;
    bus.req_store    = st;
    bus.req_size     = 2'(sz);
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    while (!bus.req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("req_ready_wait", {63'b0, bus.req_ready}, 64'd1);
    if (push) begin
      e.rdata = er;
      e.err   = ee;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int exp_lat, input string name);
    int lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_req(input string name, input bit st, input int sz, input bit uns,
                        input logic [63:0] a, input logic [63:0] wd, input logic [63:0] er,
                        input bit ee, input int lat, input int we_exp);
    int w0 = we_cycles;
    issue(st, sz, uns, a, wd, 1'b1, er, ee);
    wait_resp(lat, name);
    drain();
    chk({name, "_we_cycles"}, 64'(we_cycles - w0), 64'(we_exp));
  endtask

  initial begin
    int w0;
    bus.req_valid    = 1'b0;
    bus.req_store    = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.resp_ready   = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[2] = 64'h8877665544332211;
    mem[5] = 64'h0123456789ABCDEF;

    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Loads from entry 2
    do_req("ld_b_s",   0, 0, 0, 64'h17, 64'h0, 64'hFFFFFFFFFFFFFF88, 0, 2, 0);
    do_req("ld_h_u",   0, 1, 1, 64'h12, 64'h0, 64'h0000000000004433, 0, 2, 0);
    do_req("ld_w_s",   0, 2, 0, 64'h14, 64'h0, 64'hFFFFFFFF88776655, 0, 2, 0);
    do_req("ld_d_u",   0, 3, 1, 64'h10, 64'h0, 64'h8877665544332211, 0, 2, 0);

    // Partial store read-modify-write into entry 1
    do_req("st_w",     1, 2, 0, 64'h0C, 64'hDEADBEEF, 64'h0, 0, 3, 1);
    chk("st_w_mem1", mem[1], 64'hDEADBEEF00000000);
    do_req("ld_d_1",   0, 3, 0, 64'h08, 64'h0, 64'hDEADBEEF00000000, 0, 2, 0);

    // Doubleword store, then half merge into the same entry
    do_req("st_d",     1, 3, 0, 64'h18, 64'h1122334455667788, 64'h0, 0, 2, 1);
    chk("st_d_mem3", mem[3], 64'h1122334455667788);
    do_req("st_h",     1, 1, 0, 64'h1A, 64'h123456789ABCA5B6, 64'h0, 0, 3, 1);
    chk("st_h_mem3", mem[3], 64'h11223344A5B67788);
    do_req("ld_b_u",   0, 0, 1, 64'h1B, 64'h0, 64'h00000000000000A5, 0, 2, 0);

    // Errors: misaligned load, out-of-range store
    do_req("err_mis",  0, 2, 0, 64'h06, 64'h0, 64'h0, 1, 1, 0);
    do_req("err_rng",  1, 3, 0, 64'h800, 64'hCAFEF00DCAFEF00D, 64'h0, 1, 1, 0);
    chk("err_rng_mem0", mem[0], 64'h0);

    // Response backpressure with a competing request held on the bus
    w0 = we_cycles;
    bus.resp_ready = 1'b0;
    issue(0, 0, 1, 64'h10, 64'h0, 1'b1, 64'h11, 1'b0);
    wait_resp(2, "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (i == 0) begin
        bus.req_valid = 1'b1;
        bus.req_store = 1'b1;
        bus.req_size  = 2'd0;
        bus.req_addr  = 64'h10;
        bus.req_wdata = 64'hEE;
      end
      chk("bp_resp_valid", {63'b0, bus.resp_valid}, 64'd1);
      chk("bp_resp_rdata", bus.resp_rdata, 64'h11);
      chk("bp_req_ready",  {63'b0, bus.req_ready}, 64'd0);
      chk("bp_busy",       {63'b0, busy}, 64'd1);
    end
    @(negedge clock);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    drain();
    chk("bp_we_cycles", 64'(we_cycles - w0), 64'd0);
    chk("bp_mem2", mem[2], 64'h8877665544332211);

    // Asynchronous reset while a partial store is in WRITE
    w0 = we_cycles;
    issue(1, 0, 0, 64'h28, 64'hFF, 1'b0, 64'h0, 1'b0);
    @(posedge clock);
    #1;
    chk("rst_we_in_write", {63'b0, bus.mem_we}, 64'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("rst_mem5", mem[5], 64'h0123456789ABCDEF);
    chk("rst_we_cycles", 64'(we_cycles - w0), 64'd0);
    reset = 1'b0;
    do_req("post_rst", 0, 3, 0, 64'h28, 64'h0, 64'h0123456789ABCDEF, 0, 2, 0);

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store initiator that sits between the datapath and the 256-entry, 64-bit data memory.
- The memory has a combinational read, a synchronous write on the clock edge, and is indexed by doubleword.
- mem_lsu takes byte-addressed requests of byte, half, word or doubleword size and turns them into memory-port cycles.
- It performs read-modify-write for partial stores, sign- or zero-extends loads, and returns results over a valid/ready response channel.

Parameters:
- DEPTH_LOG2, 8: log2 of the number of memory entries; a doubleword index must be below 2**DEPTH_LOG2.
- XLEN, 64: data and address width. Fixed at 64; the parameter is documentation only.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = doubleword.
- req_unsigned  in  1  zero-extend the load result when 1.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, right-aligned (value in the low bits).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  64  extended load data; 0 for stores and errors.
- resp_err  out  1  request was misaligned or out of range.
- mem_addr  out  64  doubleword index, equal to {zeros, addr[DEPTH_LOG2+2:3]}.
- mem_wdata  out  64  write data to memory.
- mem_we  out  1  memory write enable.
- mem_rdata  in  64  combinational memory read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state = IDLE; req_ready = 1; resp_valid = 0; resp_err = 0; resp_rdata = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; busy = 0.
- Reset is asynchronous and acts mid-operation. mem_we must fall immediately, with no partial write committed after reset asserts. Any pending response is dropped.
- Only IDLE accepts requests. req_ready = 1 only in IDLE.
- On accept, latch addr, size, store flag, unsigned flag and wdata.
- Error check is performed at accept:
  - misaligned when addr mod (1 << size) != 0;
  - out of range when addr[63:3] >= 2**DEPTH_LOG2.
  - On error, go to RESP with resp_err = 1 and no memory write.
  - Otherwise go to ACCESS.
- ACCESS: mem_addr = latched index.
  - Load: capture the selected lane of mem_rdata, shifted right by 8*addr[2:0], then sign- or zero-extend by size. Go to RESP.
  - Doubleword store: mem_we = 1, mem_wdata = wdata; the memory commits at the end of this cycle. Go to RESP.
  - Partial store: capture mem_rdata into a merge register. Go to WRITE.
- WRITE: mem_we = 1. mem_wdata = the merge register with lane bytes [addr[2:0] .. addr[2:0] + (1 << size) - 1] replaced by the low bytes of wdata. Go to RESP.
- RESP: resp_valid = 1. resp_rdata and resp_err are held stable until resp_ready. When resp_valid and resp_ready are both high, go to IDLE. resp_ready is ignored outside RESP.
- mem_we is high only in ACCESS (doubleword store) and in WRITE.
- Latency from accept edge to resp_valid:
  - load: 2 cycles;
  - doubleword store: 2 cycles;
  - partial store: 3 cycles;
  - error: 1 cycle.
- Back-to-back operation: after the RESP handshake, the next accept is possible on the following cycle. There is no overlap, so at most one request is outstanding.
- Sign extension of doubleword loads is an identity; req_unsigned is ignored for size 3.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - state encoding IDLE/ACCESS/WRITE/RESP;
  - constant MEM_DEPTH_LOG2 = 8.
- One natural sub-module, lsu_lane: a combinational unit that performs both lane extract + extend and byte-lane merge from (addr[2:0], size, unsigned, data). It is shared by the load and partial-store paths.

Test Plan:
- Preload entry 2 = 0x8877665544332211; load byte at addr 0x17, signed -> resp_rdata = 0xFFFFFFFFFFFFFF88, resp_err = 0, resp_valid on the 2nd edge after accept.
- Same entry; load half at addr 0x12, unsigned -> resp_rdata = 0x0000000000004433.
- Entry 1 = 0x0; store word 0xDEADBEEF at addr 0x0C -> two cycles with mem_we high only in WRITE; entry 1 = 0xDEADBEEF00000000; a following load of entry 1 confirms.
- Load word at addr 0x06 -> resp_err = 1 after 1 cycle, mem_we never high; store at addr 0x800 (index 256) -> resp_err = 1, no write.
- Hold resp_ready low for 5 cycles during RESP -> resp_valid and resp_rdata stable, req_ready = 0; a new req_valid is ignored until the handshake completes.
- Assert reset during WRITE of a partial store -> mem_we drops the same cycle, the target entry keeps its old value, and all outputs return to their reset values.
